// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the 16x32 register file: round-robin sharing of the general
// write port plus merge of r15-directed writes with the fetch unit's PC update.
module regfile_wb_arbiter #(
   parameter int NREQ = 3,
   parameter int DW   = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [4*NREQ-1:0]    req_addr,
   input  logic [DW*NREQ-1:0]   req_data,
   output logic [NREQ-1:0]      req_ready,
   input  logic                 wb_hold,
   input  logic                 pc_wen,
   input  logic [DW-1:0]        pc_data,
   output logic                 wEn1,
   output logic [3:0]           wA1,
   output logic [DW-1:0]        wD1,
   output logic                 wEn15,
   output logic [DW-1:0]        wDr15,
   output logic [15:0]          wr_pending
);

   localparam int PW = $clog2(NREQ);

   logic [PW-1:0] ptr_q, ptr_d;
   logic          wen1_q, wen1_d;
   logic [3:0]    wa1_q, wa1_d;
   logic [DW-1:0] wd1_q, wd1_d;
   logic          wen15_q, wen15_d;
   logic [DW-1:0] wdr15_q, wdr15_d;

   logic [NREQ-1:0] grant_s;
   logic [PW-1:0]   gidx_s;
   logic            found_s;
   logic            accept_s;
   logic [3:0]      sel_addr_s;
   logic [DW-1:0]   sel_data_s;
   logic            is_r15_s;

   // Round-robin scan starting just after the last granted requester.
   always_comb begin
      grant_s = '0;
      gidx_s  = ptr_q;
      found_s = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         if (!found_s && req_valid[(int'(ptr_q) + k) % NREQ]) begin
            found_s = 1'b1;
            gidx_s  = PW'((int'(ptr_q) + k) % NREQ);
         end else begin
            found_s = found_s;
         end
      end
      if (found_s && !wb_hold && !reset) begin
         grant_s[gidx_s] = 1'b1;
      end else begin
         grant_s = '0;
      end
   end

   assign req_ready  = grant_s;
   assign accept_s   = |(req_valid & grant_s);
   assign sel_addr_s = req_addr[int'(gidx_s)*4 +: 4];
   assign sel_data_s = req_data[int'(gidx_s)*DW +: DW];
   assign is_r15_s   = (sel_addr_s == 4'd15);

   // Next-state for pointer and write-port registers; an r15 grant pre-empts the PC update.
   always_comb begin
      ptr_d   = ptr_q;
      wen1_d  = 1'b0;
      wa1_d   = wa1_q;
      wd1_d   = wd1_q;
      wen15_d = pc_wen;
      wdr15_d = wdr15_q;
      if (accept_s) begin
         ptr_d = gidx_s;
      end else begin
         ptr_d = ptr_q;
      end
      if (accept_s && !is_r15_s) begin
         wen1_d = 1'b1;
         wa1_d  = sel_addr_s;
         wd1_d  = sel_data_s;
      end else begin
         wen1_d = 1'b0;
      end
      if (accept_s && is_r15_s) begin
         wen15_d = 1'b1;
         wdr15_d = sel_data_s;
      end else if (pc_wen) begin
         wen15_d = 1'b1;
         wdr15_d = pc_data;
      end else begin
         wen15_d = 1'b0;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q   <= PW'(NREQ - 1);
         wen1_q  <= 1'b0;
         wa1_q   <= 4'd0;
         wd1_q   <= '0;
         wen15_q <= 1'b0;
         wdr15_q <= '0;
      end else begin
         ptr_q   <= ptr_d;
         wen1_q  <= wen1_d;
         wa1_q   <= wa1_d;
         wd1_q   <= wd1_d;
         wen15_q <= wen15_d;
         wdr15_q <= wdr15_d;
      end
   end

   assign wEn1  = wen1_q;
   assign wA1   = wa1_q;
   assign wD1   = wd1_q;
   assign wEn15 = wen15_q;
   assign wDr15 = wdr15_q;

   // Hazard vector decoded from the registered write strobes.
   always_comb begin
      wr_pending = 16'd0;
      if (wen1_q) begin
         wr_pending[wa1_q] = 1'b1;
      end else begin
         wr_pending = 16'd0;
      end
      if (wen15_q) begin
         wr_pending[15] = 1'b1;
      end else begin
         wr_pending[15] = wr_pending[15];
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench: stimulus pushes hand-computed per-cycle expectations into a queue,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_regfile_wb_arbiter;

   logic         clk = 1'b0;
   logic         reset;
   logic [2:0]   req_valid;
   logic [11:0]  req_addr;
   logic [95:0]  req_data;
   logic [2:0]   req_ready;
   logic         wb_hold;
   logic         pc_wen;
   logic [31:0]  pc_data;
   logic         wEn1;
   logic [3:0]   wA1;
   logic [31:0]  wD1;
   logic         wEn15;
   logic [31:0]  wDr15;
   logic [15:0]  wr_pending;

   typedef struct {
      logic [2:0]  rdy;
      logic        wen1;
      logic [3:0]  wa1;
      logic [31:0] wd1;
      logic        wen15;
      logic [31:0] wdr15;
      logic [15:0] pend;
   } exp_t;

   exp_t exp_q[$];
   int   n_total = 0;
   int   n_pass  = 0;
   int   cyc     = 0;

   regfile_wb_arbiter #(.NREQ(3), .DW(32)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
      .req_ready(req_ready), .wb_hold(wb_hold),
      .pc_wen(pc_wen), .pc_data(pc_data),
      .wEn1(wEn1), .wA1(wA1), .wD1(wD1),
      .wEn15(wEn15), .wDr15(wDr15), .wr_pending(wr_pending)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL cycle %0d %s: got 0x%0h expected 0x%0h", cyc, name, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic expect_cyc(input logic [2:0] rdy, input logic wen1, input logic [3:0] wa1,
                             input logic [31:0] wd1, input logic wen15, input logic [31:0] wdr15,
                             input logic [15:0] pend);
      exp_t e;
      e.rdy = rdy; e.wen1 = wen1; e.wa1 = wa1; e.wd1 = wd1;
      e.wen15 = wen15; e.wdr15 = wdr15; e.pend = pend;
      exp_q.push_back(e);
   endtask

   task automatic drive(input logic rst, input logic [2:0] v, input logic [11:0] a,
                        input logic [95:0] d, input logic hold, input logic pw, input logic [31:0] pd);
      reset = rst; req_valid = v; req_addr = a; req_data = d;
      wb_hold = hold; pc_wen = pw; pc_data = pd;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Monitor: compare every presented cycle against the queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("req_ready",  {29'd0, req_ready}, {29'd0, e.rdy});
            chk("wEn1",       {31'd0, wEn1},      {31'd0, e.wen1});
            chk("wA1",        {28'd0, wA1},       {28'd0, e.wa1});
            chk("wD1",        wD1,                e.wd1);
            chk("wEn15",      {31'd0, wEn15},     {31'd0, e.wen15});
            chk("wDr15",      wDr15,              e.wdr15);
            chk("wr_pending", {16'd0, wr_pending}, {16'd0, e.pend});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   localparam logic [11:0] A123  = {4'd3, 4'd2, 4'd1};
   localparam logic [95:0] DABC  = {32'hC, 32'hB, 32'hA};

   initial begin
      // reset for two edges with every request and the PC update asserted
      drive(1'b1, 3'b111, A123, DABC, 1'b0, 1'b1, 32'h44);
      step();
      expect_cyc(3'b000, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 16'h0000);
      step();
      // round-robin 0,1,2,0,1,2
      drive(1'b0, 3'b111, A123, DABC, 1'b0, 1'b0, 32'h0);
      expect_cyc(3'b001, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 16'h0000); step();
      expect_cyc(3'b010, 1'b1, 4'd1, 32'hA, 1'b0, 32'h0, 16'h0002); step();
      expect_cyc(3'b100, 1'b1, 4'd2, 32'hB, 1'b0, 32'h0, 16'h0004); step();
      expect_cyc(3'b001, 1'b1, 4'd3, 32'hC, 1'b0, 32'h0, 16'h0008); step();
      expect_cyc(3'b010, 1'b1, 4'd1, 32'hA, 1'b0, 32'h0, 16'h0002); step();
      expect_cyc(3'b100, 1'b1, 4'd2, 32'hB, 1'b0, 32'h0, 16'h0004); step();
      // only requester 2 valid: granted every cycle
      drive(1'b0, 3'b100, A123, DABC, 1'b0, 1'b0, 32'h0);
      expect_cyc(3'b100, 1'b1, 4'd3, 32'hC, 1'b0, 32'h0, 16'h0008); step();
      expect_cyc(3'b100, 1'b1, 4'd3, 32'hC, 1'b0, 32'h0, 16'h0008); step();
      expect_cyc(3'b100, 1'b1, 4'd3, 32'hC, 1'b0, 32'h0, 16'h0008); step();
      // requesters 0 and 2 with ptr=2: requester 0 wins
      drive(1'b0, 3'b101, A123, DABC, 1'b0, 1'b0, 32'h0);
      expect_cyc(3'b001, 1'b1, 4'd3, 32'hC, 1'b0, 32'h0, 16'h0008); step();
      // branch write to r15 overrides the same-cycle PC update
      drive(1'b0, 3'b010, {4'd3, 4'd15, 4'd1}, {32'hC, 32'h100, 32'hA}, 1'b0, 1'b1, 32'h44);
      expect_cyc(3'b010, 1'b1, 4'd1, 32'hA, 1'b0, 32'h0, 16'h0002); step();
      drive(1'b0, 3'b000, A123, DABC, 1'b0, 1'b1, 32'h48);
      expect_cyc(3'b000, 1'b0, 4'd1, 32'hA, 1'b1, 32'h100, 16'h8000); step();
      drive(1'b0, 3'b000, A123, DABC, 1'b0, 1'b0, 32'h0);
      expect_cyc(3'b000, 1'b0, 4'd1, 32'hA, 1'b1, 32'h48, 16'h8000); step();
      // hold for three cycles; PC path keeps running
      drive(1'b0, 3'b011, A123, DABC, 1'b1, 1'b1, 32'h50);
      expect_cyc(3'b000, 1'b0, 4'd1, 32'hA, 1'b0, 32'h48, 16'h0000); step();
      drive(1'b0, 3'b011, A123, DABC, 1'b1, 1'b1, 32'h54);
      expect_cyc(3'b000, 1'b0, 4'd1, 32'hA, 1'b1, 32'h50, 16'h8000); step();
      drive(1'b0, 3'b011, A123, DABC, 1'b1, 1'b1, 32'h58);
      expect_cyc(3'b000, 1'b0, 4'd1, 32'hA, 1'b1, 32'h54, 16'h8000); step();
      // release: ptr=1 saved, so requester 0 then 1
      drive(1'b0, 3'b011, A123, DABC, 1'b0, 1'b0, 32'h0);
      expect_cyc(3'b001, 1'b0, 4'd1, 32'hA, 1'b1, 32'h58, 16'h8000); step();
      expect_cyc(3'b010, 1'b1, 4'd1, 32'hA, 1'b0, 32'h58, 16'h0002); step();
      // simultaneous general write to r5 and PC update
      drive(1'b0, 3'b001, {4'd3, 4'd2, 4'd5}, {32'hC, 32'hB, 32'h55}, 1'b0, 1'b1, 32'h80);
      expect_cyc(3'b001, 1'b1, 4'd2, 32'hB, 1'b0, 32'h58, 16'h0004); step();
      drive(1'b0, 3'b000, {4'd3, 4'd2, 4'd5}, {32'hC, 32'hB, 32'h55}, 1'b0, 1'b0, 32'h0);
      expect_cyc(3'b000, 1'b1, 4'd5, 32'h55, 1'b1, 32'h80, 16'h8020); step();
      // mid-stream reset discards a registered write and re-arms requester 0 priority
      drive(1'b0, 3'b001, {4'd3, 4'd2, 4'd5}, {32'hC, 32'hB, 32'h55}, 1'b0, 1'b0, 32'h0);
      expect_cyc(3'b001, 1'b0, 4'd5, 32'h55, 1'b0, 32'h80, 16'h0000); step();
      drive(1'b1, 3'b001, {4'd3, 4'd2, 4'd5}, {32'hC, 32'hB, 32'h55}, 1'b0, 1'b1, 32'h90);
      expect_cyc(3'b000, 1'b1, 4'd5, 32'h55, 1'b0, 32'h80, 16'h0020); step();
      drive(1'b0, 3'b000, A123, DABC, 1'b0, 1'b0, 32'h0);
      expect_cyc(3'b000, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 16'h0000); step();
      drive(1'b0, 3'b011, A123, DABC, 1'b0, 1'b0, 32'h0);
      expect_cyc(3'b001, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 16'h0000); step();
      drive(1'b0, 3'b000, A123, DABC, 1'b0, 1'b0, 32'h0);
      expect_cyc(3'b000, 1'b1, 4'd1, 32'hA, 1'b0, 32'h0, 16'h0002); step();
      @(negedge clk);
      #1;
      chk("queue_drained", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
